// File: rtl/axi_mem_slave_if.sv
// -----------------------------------------------------------------------------
// axi_mem_slave_if
// AXI4 bus bundle between the traffic-generator master and axi_mem_slave.
// Carries the five AXI4 channels (AW, W, B, AR, R) without clock or reset.
// Clock and reset stay as plain ports on the modules.
//   slave  modport : used by axi_mem_slave (ready/resp/data outputs)
//   master modport : used by the traffic source (valid/addr/data outputs)
// -----------------------------------------------------------------------------
interface axi_mem_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
);
  // write address channel
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [1:0]        awburst;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [3:0]        awcache;
  // write data channel
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  // write response channel
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  // read address channel
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [1:0]        arburst;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [3:0]        arcache;
  // read data channel
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
  logic [1:0]        rresp;

  modport slave (
    input  awvalid, awaddr, awburst, awlen, awsize, awcache,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arburst, arlen, arsize, arcache,
    output arready,
    output rvalid, rdata, rlast, rresp,
    input  rready
  );

  modport master (
    output awvalid, awaddr, awburst, awlen, awsize, awcache,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arburst, arlen, arsize, arcache,
    input  arready,
    input  rvalid, rdata, rlast, rresp,
    output rready
  );
endinterface

// File: rtl/axi_mem_slave.sv
// -----------------------------------------------------------------------------
// axi_mem_slave
// AXI4 slave backed by an on-chip word memory. Terminates write and read
// bursts (single-beat, INCR, FIXED) with byte strobes and returns OKAY or
// SLVERR. Write and read channels run independently.
// Ports:
//   axi_aclk     : clock
//   axi_aresetn  : asynchronous active-low reset
//   s_axi        : AXI4 bus (axi_mem_slave_if.slave)
//   err_cnt      : saturating count of SLVERR responses (B responses and R beats)
// All outputs are registered; memory contents are not reset.
// -----------------------------------------------------------------------------
module axi_mem_slave #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int STRB_W    = DATA_W / 8,
  parameter int MEM_DEPTH = 512
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  axi_mem_slave_if.slave        s_axi,
  output logic [15:0]           err_cnt
);

  localparam int IDX_LSB = $clog2(STRB_W);
  localparam int IDX_W   = $clog2(MEM_DEPTH);

  localparam logic [1:0] BURST_INCR = 2'd1;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SLV   = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input logic [1:0] burst);
    // INCR wraps naturally at MEM_DEPTH-1; FIXED and illegal bursts hold.
    return (burst == BURST_INCR) ? idx + IDX_W'(1) : idx;
  endfunction

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // write channel state
  w_state_t          w_state_q, w_state_nxt;
  logic              awready_q, awready_nxt;
  logic              wready_q,  wready_nxt;
  logic              bvalid_q,  bvalid_nxt;
  logic [1:0]        bresp_q,   bresp_nxt;
  logic [IDX_W-1:0]  w_idx_q,   w_idx_nxt;
  logic [1:0]        w_burst_q, w_burst_nxt;
  logic [7:0]        w_len_q,   w_len_nxt;
  logic [7:0]        w_beat_q,  w_beat_nxt;
  logic              w_err_q,   w_err_nxt;
  logic              mem_we;
  logic              b_err_issue;
  logic              w_last_beat;
  logic              w_beat_err;

  // read channel state
  r_state_t          r_state_q, r_state_nxt;
  logic              arready_q, arready_nxt;
  logic              rvalid_q,  rvalid_nxt;
  logic [DATA_W-1:0] rdata_q,   rdata_nxt;
  logic              rlast_q,   rlast_nxt;
  logic [1:0]        rresp_q,   rresp_nxt;
  logic [IDX_W-1:0]  r_idx_q,   r_idx_nxt;
  logic [1:0]        r_burst_q, r_burst_nxt;
  logic [7:0]        r_len_q,   r_len_nxt;
  logic [7:0]        r_beat_q,  r_beat_nxt;
  logic              r_err_issue;

  logic [15:0]       err_cnt_q;

  // Size/cache qualifiers and the address bits outside the word index do not
  // affect behaviour.
  logic unused_sink;
  assign unused_sink = ^{s_axi.awsize, s_axi.awcache, s_axi.arsize, s_axi.arcache,
                         s_axi.awaddr, s_axi.araddr};

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rresp   = rresp_q;
  assign err_cnt       = err_cnt_q;

  // ---------------------------------------------------------------------------
  // Write FSM: next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = w_state_q;
    awready_nxt = awready_q;
    wready_nxt  = wready_q;
    bvalid_nxt  = bvalid_q;
    bresp_nxt   = bresp_q;
    w_idx_nxt   = w_idx_q;
    w_burst_nxt = w_burst_q;
    w_len_nxt   = w_len_q;
    w_beat_nxt  = w_beat_q;
    w_err_nxt   = w_err_q;
    mem_we      = 1'b0;
    b_err_issue = 1'b0;
    w_last_beat = (w_beat_q == w_len_q);
    // wlast must coincide exactly with the final counted beat
    w_beat_err  = w_err_q || (s_axi.wlast != w_last_beat);

    unique case (w_state_q)
      W_IDLE: begin
        // Also raises awready on the first edge after reset.
        awready_nxt = 1'b1;
        if (s_axi.awvalid && awready_q) begin
          w_idx_nxt   = s_axi.awaddr[IDX_LSB +: IDX_W];
          w_burst_nxt = s_axi.awburst;
          w_len_nxt   = s_axi.awlen;
          w_beat_nxt  = 8'd0;
          // illegal burst type poisons the whole burst up front
          w_err_nxt   = s_axi.awburst[1];
          awready_nxt = 1'b0;
          wready_nxt  = 1'b1;
          w_state_nxt = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi.wvalid && wready_q) begin
          mem_we    = !w_burst_q[1];
          w_err_nxt = w_beat_err;
          if (w_last_beat) begin
            wready_nxt  = 1'b0;
            bvalid_nxt  = 1'b1;
            bresp_nxt   = w_beat_err ? RESP_SLV : RESP_OKAY;
            b_err_issue = w_beat_err;
            w_state_nxt = W_RESP;
          end else begin
            w_beat_nxt = w_beat_q + 8'd1;
            w_idx_nxt  = next_idx(w_idx_q, w_burst_q);
          end
        end
      end
      W_RESP: begin
        if (s_axi.bready) begin
          bvalid_nxt  = 1'b0;
          awready_nxt = 1'b1;
          w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read FSM: next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    r_state_nxt = r_state_q;
    arready_nxt = arready_q;
    rvalid_nxt  = rvalid_q;
    rdata_nxt   = rdata_q;
    rlast_nxt   = rlast_q;
    rresp_nxt   = rresp_q;
    r_idx_nxt   = r_idx_q;
    r_burst_nxt = r_burst_q;
    r_len_nxt   = r_len_q;
    r_beat_nxt  = r_beat_q;
    r_err_issue = 1'b0;

    unique case (r_state_q)
      R_IDLE: begin
        arready_nxt = 1'b1;
        if (s_axi.arvalid && arready_q) begin
          r_idx_nxt   = s_axi.araddr[IDX_LSB +: IDX_W];
          r_burst_nxt = s_axi.arburst;
          r_len_nxt   = s_axi.arlen;
          r_beat_nxt  = 8'd0;
          arready_nxt = 1'b0;
          r_state_nxt = R_FETCH;
        end
      end
      R_FETCH: begin
        // Sampled before this edge's write lands: read-before-write on collision.
        rdata_nxt   = mem[r_idx_q];
        rlast_nxt   = (r_beat_q == r_len_q);
        rresp_nxt   = r_burst_q[1] ? RESP_SLV : RESP_OKAY;
        r_err_issue = r_burst_q[1];
        rvalid_nxt  = 1'b1;
        r_state_nxt = R_DATA;
      end
      R_DATA: begin
        if (s_axi.rready) begin
          rvalid_nxt = 1'b0;
          if (rlast_q) begin
            arready_nxt = 1'b1;
            r_state_nxt = R_IDLE;
          end else begin
            r_beat_nxt  = r_beat_q + 8'd1;
            r_idx_nxt   = next_idx(r_idx_q, r_burst_q);
            r_state_nxt = R_FETCH;
          end
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      w_idx_q   <= '0;
      w_burst_q <= 2'b00;
      w_len_q   <= 8'd0;
      w_beat_q  <= 8'd0;
      w_err_q   <= 1'b0;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'b00;
      r_idx_q   <= '0;
      r_burst_q <= 2'b00;
      r_len_q   <= 8'd0;
      r_beat_q  <= 8'd0;
      err_cnt_q <= 16'd0;
    end else begin
      w_state_q <= w_state_nxt;
      awready_q <= awready_nxt;
      wready_q  <= wready_nxt;
      bvalid_q  <= bvalid_nxt;
      bresp_q   <= bresp_nxt;
      w_idx_q   <= w_idx_nxt;
      w_burst_q <= w_burst_nxt;
      w_len_q   <= w_len_nxt;
      w_beat_q  <= w_beat_nxt;
      w_err_q   <= w_err_nxt;
      r_state_q <= r_state_nxt;
      arready_q <= arready_nxt;
      rvalid_q  <= rvalid_nxt;
      rdata_q   <= rdata_nxt;
      rlast_q   <= rlast_nxt;
      rresp_q   <= rresp_nxt;
      r_idx_q   <= r_idx_nxt;
      r_burst_q <= r_burst_nxt;
      r_len_q   <= r_len_nxt;
      r_beat_q  <= r_beat_nxt;
      // B and R may both report SLVERR in the same cycle
      err_cnt_q <= sat_add16(err_cnt_q, {1'b0, b_err_issue} + {1'b0, r_err_issue});
    end
  end

  // ---------------------------------------------------------------------------
  // Memory write port with byte strobes
  // ---------------------------------------------------------------------------
  always_ff @(posedge axi_aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.wstrb[b]) begin
          mem[w_idx_q][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_mem_slave
// Directed bench for axi_mem_slave: a table of single-beat write/read vectors
// plus hand-written sequences for bursts, errors, collision and mid-burst reset.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_mem_slave;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int STRB_W    = 4;
  localparam int MEM_DEPTH = 512;
  localparam int TMO       = 200;

  logic        axi_aclk    = 1'b0;
  logic        axi_aresetn = 1'b0;
  logic [15:0] err_cnt;

  int nvec = 0;
  int nmis = 0;

  logic [31:0] wbuf  [16];
  logic [3:0]  sbuf  [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic        rd_stable [16];

  always #5 axi_aclk = ~axi_aclk;

  axi_mem_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) bus ();

  axi_mem_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W), .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .s_axi       (bus),
    .err_cnt     (err_cnt)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    nvec++;
    nmis++;
    $display("FAIL %s: timed out after %0d cycles", name, TMO);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [1:0] burst, input logic [7:0] len,
                           input int wlast_at, input int bdelay,
                           output logic [1:0] resp, output int held);
    int to;
    resp = 2'bxx;
    held = 0;
    @(negedge axi_aclk);
    bus.awvalid = 1'b1; bus.awaddr = addr; bus.awburst = burst; bus.awlen = len;
    bus.awsize = 3'd2; bus.awcache = 4'd0;
    bus.wvalid = 1'b1; bus.wdata = wbuf[0]; bus.wstrb = sbuf[0]; bus.wlast = (wlast_at == 0);
    to = 0;
    while (!bus.awready && to < TMO) begin @(negedge axi_aclk); to++; end
    if (to >= TMO) begin
      timeout_fail("aw_handshake");
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      return;
    end
    @(negedge axi_aclk);
    bus.awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      bus.wdata = wbuf[b]; bus.wstrb = sbuf[b]; bus.wlast = (b == wlast_at); bus.wvalid = 1'b1;
      to = 0;
      while (!bus.wready && to < TMO) begin @(negedge axi_aclk); to++; end
      if (to >= TMO) begin
        timeout_fail("w_handshake");
        bus.wvalid = 1'b0;
        return;
      end
      @(negedge axi_aclk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    to = 0;
    while (!bus.bvalid && to < TMO) begin @(negedge axi_aclk); to++; end
    if (to >= TMO) begin
      timeout_fail("b_wait");
      return;
    end
    for (int d = 0; d < bdelay; d++) begin
      if (bus.bvalid) held++;
      @(negedge axi_aclk);
    end
    resp = bus.bresp;
    bus.bready = 1'b1;
    @(negedge axi_aclk);
    bus.bready = 1'b0;
    check("bvalid_drop", {31'd0, bus.bvalid}, 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [1:0] burst, input logic [7:0] len,
                          input bit stall);
    int to;
    for (int b = 0; b < 16; b++) begin
      rd_data[b] = 'x; rd_resp[b] = 'x; rd_last[b] = 1'bx; rd_stable[b] = 1'b0;
    end
    @(negedge axi_aclk);
    bus.arvalid = 1'b1; bus.araddr = addr; bus.arburst = burst; bus.arlen = len;
    bus.arsize = 3'd2; bus.arcache = 4'd0;
    to = 0;
    while (!bus.arready && to < TMO) begin @(negedge axi_aclk); to++; end
    if (to >= TMO) begin
      timeout_fail("ar_handshake");
      bus.arvalid = 1'b0;
      return;
    end
    @(negedge axi_aclk);
    bus.arvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      to = 0;
      while (!bus.rvalid && to < TMO) begin @(negedge axi_aclk); to++; end
      if (to >= TMO) begin
        timeout_fail("r_wait");
        return;
      end
      rd_data[b] = bus.rdata; rd_resp[b] = bus.rresp; rd_last[b] = bus.rlast; rd_stable[b] = 1'b1;
      if (stall) begin
        @(negedge axi_aclk);
        if (!bus.rvalid || bus.rdata !== rd_data[b] || bus.rlast !== rd_last[b]) rd_stable[b] = 1'b0;
      end
      bus.rready = 1'b1;
      @(negedge axi_aclk);
      bus.rready = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [8];
    logic [1:0]  resp;
    int          held;
    int          to;

    tbl[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_0001, 4'hF, 32'h0,          "wr_single"};
    tbl[1] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hA5A5_0001,  "rd_single"};
    tbl[2] = '{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 32'h0,          "wr_ones"};
    tbl[3] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'h5, 32'h0,          "wr_strb0101"};
    tbl[4] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hFF34_FF78,  "rd_strb0101"};
    tbl[5] = '{1'b0, 32'h0000_0820, 32'h0,         4'h0, 32'hFF34_FF78,  "rd_alias"};
    tbl[6] = '{1'b1, 32'h0000_0024, 32'hFFFF_0000, 4'hF, 32'h0,          "wr_word24"};
    tbl[7] = '{1'b1, 32'h0000_0024, 32'h0000_AB00, 4'h2, 32'h0,          "wr_strb0010"};

    bus.awvalid = 0; bus.awaddr = 0; bus.awburst = 0; bus.awlen = 0; bus.awsize = 0; bus.awcache = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.arburst = 0; bus.arlen = 0; bus.arsize = 0; bus.arcache = 0;
    bus.rready = 0;

    // reset state
    repeat (3) @(negedge axi_aclk);
    check("rst_awready", {31'd0, bus.awready}, 32'd0);
    check("rst_arready", {31'd0, bus.arready}, 32'd0);
    check("rst_wready",  {31'd0, bus.wready},  32'd0);
    check("rst_bvalid",  {31'd0, bus.bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, bus.rvalid},  32'd0);
    check("rst_rdata",   bus.rdata,            32'd0);
    check("rst_err_cnt", {16'd0, err_cnt},     32'd0);
    axi_aresetn = 1'b1;
    check("awready_before_edge", {31'd0, bus.awready}, 32'd0);
    @(negedge axi_aclk);
    check("awready_after_edge", {31'd0, bus.awready}, 32'd1);
    check("arready_after_edge", {31'd0, bus.arready}, 32'd1);

    // table-driven single-beat vectors
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].is_wr) begin
        wbuf[0] = tbl[i].data; sbuf[0] = tbl[i].strb;
        axi_write(tbl[i].addr, 2'd1, 8'd0, 0, 0, resp, held);
        check({tbl[i].name, "_bresp"}, {30'd0, resp}, 32'd0);
      end else begin
        axi_read(tbl[i].addr, 2'd1, 8'd0, 1'b0);
        check({tbl[i].name, "_rdata"}, rd_data[0], tbl[i].exp);
        check({tbl[i].name, "_rlast"}, {31'd0, rd_last[0]}, 32'd1);
        check({tbl[i].name, "_rresp"}, {30'd0, rd_resp[0]}, 32'd0);
      end
    end
    axi_read(32'h24, 2'd1, 8'd0, 1'b0);
    check("rd_strb0010", rd_data[0], 32'hFFFF_AB00);
    check("err_cnt_clean", {16'd0, err_cnt}, 32'd0);

    // INCR burst wrapping past the top of memory, delayed bready
    for (int i = 0; i < 8; i++) begin wbuf[i] = i; sbuf[i] = 4'hF; end
    axi_write(32'h7F0, 2'd1, 8'd7, 7, 5, resp, held);
    check("incr_bresp", {30'd0, resp}, 32'd0);
    check("incr_bvalid_held", held, 32'd5);
    axi_read(32'h7F0, 2'd1, 8'd7, 1'b1);
    for (int b = 0; b < 8; b++) begin
      check($sformatf("incr_rdata%0d", b), rd_data[b], b);
      check($sformatf("incr_rlast%0d", b), {31'd0, rd_last[b]}, (b == 7) ? 32'd1 : 32'd0);
      check($sformatf("incr_rresp%0d", b), {30'd0, rd_resp[b]}, 32'd0);
      check($sformatf("incr_stable%0d", b), {31'd0, rd_stable[b]}, 32'd1);
    end
    axi_read(32'h7FC, 2'd1, 8'd0, 1'b0);
    check("wrap_top_word", rd_data[0], 32'd3);
    axi_read(32'h000, 2'd1, 8'd0, 1'b0);
    check("wrap_word0", rd_data[0], 32'd4);

    // illegal burst type: two beats taken, memory untouched
    wbuf[0] = 32'hBAD0_0000; wbuf[1] = 32'hBAD0_0001; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    axi_write(32'h10, 2'd2, 8'd1, 1, 0, resp, held);
    check("illegal_bresp", {30'd0, resp}, 32'd2);
    check("illegal_err_cnt", {16'd0, err_cnt}, 32'd1);
    axi_read(32'h10, 2'd1, 8'd0, 1'b0);
    check("illegal_mem_kept", rd_data[0], 32'hA5A5_0001);

    // early wlast: all four beats still taken, SLVERR
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h100 + i; sbuf[i] = 4'hF; end
    axi_write(32'h40, 2'd1, 8'd3, 1, 0, resp, held);
    check("early_wlast_bresp", {30'd0, resp}, 32'd2);
    check("early_wlast_err_cnt", {16'd0, err_cnt}, 32'd2);

    // illegal read burst
    axi_read(32'h10, 2'd3, 8'd0, 1'b0);
    check("illegal_rresp", {30'd0, rd_resp[0]}, 32'd2);
    check("illegal_rlast", {31'd0, rd_last[0]}, 32'd1);
    check("illegal_rd_err_cnt", {16'd0, err_cnt}, 32'd3);

    // traffic-generator pattern
    for (int i = 0; i < 64; i++) begin
      wbuf[0] = i; sbuf[0] = 4'hF;
      axi_write(i * 4, 2'd1, 8'd0, 0, 0, resp, held);
      check($sformatf("tg_bresp%0d", i), {30'd0, resp}, 32'd0);
    end
    for (int i = 0; i < 64; i++) begin
      axi_read(i * 4, 2'd1, 8'd0, 1'b0);
      check($sformatf("tg_rdata%0d", i), rd_data[0], i);
      check($sformatf("tg_rresp%0d", i), {30'd0, rd_resp[0]}, 32'd0);
    end
    check("tg_err_cnt", {16'd0, err_cnt}, 32'd3);

    // same-word write and read fetch on the same edge
    @(negedge axi_aclk);
    check("coll_awready", {31'd0, bus.awready}, 32'd1);
    check("coll_arready", {31'd0, bus.arready}, 32'd1);
    bus.awvalid = 1'b1; bus.awaddr = 32'h30; bus.awburst = 2'd1; bus.awlen = 8'd0;
    bus.wvalid = 1'b1; bus.wdata = 32'hC0FF_EE00; bus.wstrb = 4'hF; bus.wlast = 1'b1;
    bus.arvalid = 1'b1; bus.araddr = 32'h30; bus.arburst = 2'd1; bus.arlen = 8'd0;
    @(negedge axi_aclk);
    bus.awvalid = 1'b0; bus.arvalid = 1'b0;
    @(negedge axi_aclk);
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("coll_rvalid", {31'd0, bus.rvalid}, 32'd1);
    check("coll_old_data", bus.rdata, 32'd12);
    check("coll_bvalid", {31'd0, bus.bvalid}, 32'd1);
    check("coll_bresp", {30'd0, bus.bresp}, 32'd0);
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(negedge axi_aclk);
    bus.bready = 1'b0; bus.rready = 1'b0;
    axi_read(32'h30, 2'd1, 8'd0, 1'b0);
    check("coll_new_data", rd_data[0], 32'hC0FF_EE00);

    // reset pulsed in the middle of a read burst
    @(negedge axi_aclk);
    bus.arvalid = 1'b1; bus.araddr = 32'h0; bus.arburst = 2'd1; bus.arlen = 8'd7;
    @(negedge axi_aclk);
    bus.arvalid = 1'b0;
    to = 0;
    while (!bus.rvalid && to < TMO) begin @(negedge axi_aclk); to++; end
    if (to >= TMO) timeout_fail("rst_burst_rvalid");
    check("rst_burst_beat0", bus.rdata, 32'd0);
    axi_aresetn = 1'b0;
    #1;
    check("midrst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check("midrst_arready", {31'd0, bus.arready}, 32'd0);
    check("midrst_err_cnt", {16'd0, err_cnt}, 32'd0);
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    check("postrst_arready_low", {31'd0, bus.arready}, 32'd0);
    @(negedge axi_aclk);
    check("postrst_arready", {31'd0, bus.arready}, 32'd1);
    check("postrst_awready", {31'd0, bus.awready}, 32'd1);
    check("postrst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    axi_read(32'h4, 2'd1, 8'd0, 1'b0);
    check("postrst_rdata", rd_data[0], 32'd1);
    check("postrst_rlast", {31'd0, rd_last[0]}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
